// File: rtl/seq_alu_pkg.sv
// seq_alu_pkg: shared definitions for the sequential ALU.
//   - 5-bit alu_op encodings (base ops keep the ALU_CTRL_* values of the
//     combinational ALU; RV-M ops occupy 5'h10-5'h17 in funct3 order)
//   - FSM state enum
//   - default operand width
package seq_alu_pkg;

   localparam int SEQ_ALU_DATA_WIDTH = 32;

   // Base ops: bit 3 mirrors funct7[5], bits 2:0 mirror funct3.
   localparam logic [4:0] ALU_CTRL_ADD    = 5'h00;
   localparam logic [4:0] ALU_CTRL_SLL    = 5'h01;
   localparam logic [4:0] ALU_CTRL_SLT    = 5'h02;
   localparam logic [4:0] ALU_CTRL_SLTU   = 5'h03;
   localparam logic [4:0] ALU_CTRL_XOR    = 5'h04;
   localparam logic [4:0] ALU_CTRL_SRL    = 5'h05;
   localparam logic [4:0] ALU_CTRL_OR     = 5'h06;
   localparam logic [4:0] ALU_CTRL_AND    = 5'h07;
   localparam logic [4:0] ALU_CTRL_SUB    = 5'h08;
   localparam logic [4:0] ALU_CTRL_SRA    = 5'h0D;
   localparam logic [4:0] ALU_CTRL_COPY_B = 5'h0F;

   // RV-M ops: bits 2:0 are funct3, so bit 2 selects divide and bit 1
   // selects remainder within the divide group.
   localparam logic [4:0] ALU_CTRL_MUL    = 5'h10;
   localparam logic [4:0] ALU_CTRL_MULH   = 5'h11;
   localparam logic [4:0] ALU_CTRL_MULHSU = 5'h12;
   localparam logic [4:0] ALU_CTRL_MULHU  = 5'h13;
   localparam logic [4:0] ALU_CTRL_DIV    = 5'h14;
   localparam logic [4:0] ALU_CTRL_DIVU   = 5'h15;
   localparam logic [4:0] ALU_CTRL_REM    = 5'h16;
   localparam logic [4:0] ALU_CTRL_REMU   = 5'h17;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_e;

   function automatic logic is_mdu_op(input logic [4:0] op);
      return op[4:3] == 2'b10;
   endfunction

endpackage

// File: rtl/seq_mdu.sv
// seq_mdu: iterative RV-M multiply/divide core, one bit per cycle.
// Built only when SEQ_ALU_MDU_EN is defined (instantiated by seq_alu).
// Ports:
//   clk, rst_i     clock, synchronous active-high reset
//   start_i        load operands (op_i, a_i, b_i) and clear the counter
//   step_i         perform one iteration
//   kill_i         abandon the operation in flight
//   op_i[2:0]      funct3 of the M op
//   done_o         this step is the last one; result_o is valid with it
//   result_o       final result, derived from the last iteration's value
module seq_mdu
   import seq_alu_pkg::*;
#(
   parameter int DATA_WIDTH = SEQ_ALU_DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst_i,
   input  logic                  start_i,
   input  logic                  step_i,
   input  logic                  kill_i,
   input  logic [2:0]            op_i,
   input  logic [DATA_WIDTH-1:0] a_i,
   input  logic [DATA_WIDTH-1:0] b_i,
   output logic                  done_o,
   output logic [DATA_WIDTH-1:0] result_o
);

   localparam int W     = DATA_WIDTH;
   localparam int CNT_W = $clog2(DATA_WIDTH);

   // acc_q holds {partial product high, multiplier} for multiply and
   // {partial remainder, dividend/quotient} for divide.
   logic [2*W-1:0]   acc_q, acc_d;
   logic [W-1:0]     opnd_q;
   logic [CNT_W-1:0] cnt_q;
   logic [2:0]       op_q;
   logic             neg_q, rneg_q;

   logic             signed_a, signed_b, sgn_a, sgn_b;
   logic [W-1:0]     mag_a, mag_b;
   logic [W:0]       mul_sum, div_shift, div_diff;
   logic             qbit;
   logic [2*W-1:0]   prod;
   logic [W-1:0]     quot, rem;

   // MUL is treated as unsigned: the low half is sign-agnostic.
   assign signed_a = (op_i == 3'b001) || (op_i == 3'b010) ||
                     (op_i == 3'b100) || (op_i == 3'b110);
   assign signed_b = (op_i == 3'b001) || (op_i == 3'b100) || (op_i == 3'b110);
   assign sgn_a    = signed_a && a_i[W-1];
   assign sgn_b    = signed_b && b_i[W-1];
   assign mag_a    = sgn_a ? -a_i : a_i;
   assign mag_b    = sgn_b ? -b_i : b_i;

   assign mul_sum   = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
   assign div_shift = acc_q[2*W-1:W-1];
   assign div_diff  = div_shift - {1'b0, opnd_q};
   // Remainder stays below the divisor, so bit W of the difference is a
   // reliable borrow flag.
   assign qbit      = ~div_diff[W];

   always_comb begin
      acc_d = {mul_sum, acc_q[W-1:1]};
      if (op_q[2]) begin
         acc_d = {(qbit ? div_diff[W-1:0] : div_shift[W-1:0]), acc_q[W-2:0], qbit};
      end
   end

   assign prod = neg_q ? -acc_d : acc_d;
   assign quot = acc_d[W-1:0];
   assign rem  = acc_d[2*W-1:W];

   always_comb begin
      result_o = '0;
      if (!op_q[2]) begin
         result_o = (op_q[1:0] == 2'b00) ? prod[W-1:0] : prod[2*W-1:W];
      end else if (op_q[1]) begin
         result_o = rneg_q ? -rem : rem;
      end else begin
         result_o = neg_q ? -quot : quot;
      end
   end

   assign done_o = step_i && (cnt_q == CNT_W'(DATA_WIDTH - 1));

   always_ff @(posedge clk) begin
      if (rst_i || kill_i) begin
         acc_q  <= '0;
         opnd_q <= '0;
         cnt_q  <= '0;
         op_q   <= '0;
         neg_q  <= 1'b0;
         rneg_q <= 1'b0;
      end else if (start_i) begin
         op_q   <= op_i;
         cnt_q  <= '0;
         neg_q  <= sgn_a ^ sgn_b;
         rneg_q <= sgn_a;
         if (op_i[2]) begin
            acc_q  <= {{W{1'b0}}, mag_a};
            opnd_q <= mag_b;
         end else begin
            acc_q  <= {{W{1'b0}}, mag_b};
            opnd_q <= mag_a;
         end
      end else if (step_i) begin
         acc_q <= acc_d;
         cnt_q <= cnt_q + 1'b1;
      end
   end

endmodule

// File: rtl/seq_alu.sv
// seq_alu: handshaked execution unit. Base integer ops complete one cycle
// after accept; with SEQ_ALU_MDU_EN defined, RV-M ops run on seq_mdu for
// DATA_WIDTH cycles. Without it, M ops are reported as illegal.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid / in_ready      operand handshake (ready only in IDLE)
//   alu_op, A, B             operation and operands
//   flush                    abort anything in flight, return to IDLE
//   out_valid / out_ready    result handshake (valid only in DONE)
//   alu_out, Zero, Less      result, A==B at accept, SLT/SLTU outcome
//   illegal_op               op unknown or not built
//
// state  | meaning
// IDLE   | waiting for an operation, in_ready=1
// BUSY   | iterative multiply/divide running
// DONE   | result held, out_valid=1 until out_ready
module seq_alu
   import seq_alu_pkg::*;
#(
   parameter int DATA_WIDTH = SEQ_ALU_DATA_WIDTH,
   parameter int SHAMT_W    = $clog2(DATA_WIDTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [4:0]            alu_op,
   input  logic [DATA_WIDTH-1:0] A,
   input  logic [DATA_WIDTH-1:0] B,
   input  logic                  flush,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] alu_out,
   output logic                  Zero,
   output logic                  Less,
   output logic                  illegal_op
);

   state_e                state_q;
   logic [DATA_WIDTH-1:0] alu_out_q;
   logic                  zero_q, less_q, illegal_q;

   logic [DATA_WIDTH-1:0] base_res;
   logic                  base_less, base_legal;
   logic [SHAMT_W-1:0]    shamt;

   assign shamt = B[SHAMT_W-1:0];

   always_comb begin
      base_res   = '0;
      base_less  = 1'b0;
      base_legal = 1'b1;
      case (alu_op)
         ALU_CTRL_ADD:    base_res = A + B;
         ALU_CTRL_SUB:    base_res = A - B;
         ALU_CTRL_SLL:    base_res = A << shamt;
         ALU_CTRL_SLT: begin
            base_less = $signed(A) < $signed(B);
            base_res  = {{(DATA_WIDTH-1){1'b0}}, base_less};
         end
         ALU_CTRL_SLTU: begin
            base_less = A < B;
            base_res  = {{(DATA_WIDTH-1){1'b0}}, base_less};
         end
         ALU_CTRL_COPY_B: base_res = B;
         ALU_CTRL_XOR:    base_res = A ^ B;
         ALU_CTRL_OR:     base_res = A | B;
         ALU_CTRL_AND:    base_res = A & B;
         ALU_CTRL_SRL:    base_res = A >> shamt;
         ALU_CTRL_SRA:    base_res = $signed(A) >>> shamt;
         default:         base_legal = 1'b0;
      endcase
   end

`ifdef SEQ_ALU_MDU_EN
   localparam logic [DATA_WIDTH-1:0] DMIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

   logic                  mdu_op, div_zero, div_ovf, div_special;
   logic                  mdu_start, mdu_step, mdu_done;
   logic [DATA_WIDTH-1:0] special_res, mdu_res;

   assign mdu_op      = is_mdu_op(alu_op);
   assign div_zero    = alu_op[2] && (B == '0);
   // Only the signed divide/remainder can overflow.
   assign div_ovf     = alu_op[2] && !alu_op[0] && (A == DMIN) && (B == '1);
   assign div_special = mdu_op && (div_zero || div_ovf);
   // alu_op[1] selects remainder within the divide group.
   assign special_res = div_zero ? (alu_op[1] ? A : '1)
                                 : (alu_op[1] ? '0 : DMIN);

   assign mdu_start = (state_q == S_IDLE) && in_valid && mdu_op && !div_special && !flush;
   assign mdu_step  = (state_q == S_BUSY) && !flush;

   seq_mdu #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_mdu (
      .clk      (clk),
      .rst_i    (rst),
      .start_i  (mdu_start),
      .step_i   (mdu_step),
      .kill_i   (flush),
      .op_i     (alu_op[2:0]),
      .a_i      (A),
      .b_i      (B),
      .done_o   (mdu_done),
      .result_o (mdu_res)
   );
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         alu_out_q <= '0;
         zero_q    <= 1'b0;
         less_q    <= 1'b0;
         illegal_q <= 1'b0;
      end else if (flush) begin
         state_q <= S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (in_valid) begin
                  zero_q    <= (A == B);
                  less_q    <= base_less;
                  illegal_q <= 1'b0;
                  if (base_legal) begin
                     alu_out_q <= base_res;
                     state_q   <= S_DONE;
`ifdef SEQ_ALU_MDU_EN
                  end else if (mdu_op) begin
                     if (div_special) begin
                        alu_out_q <= special_res;
                        state_q   <= S_DONE;
                     end else begin
                        state_q   <= S_BUSY;
                     end
`endif
                  end else begin
                     alu_out_q <= '0;
                     illegal_q <= 1'b1;
                     state_q   <= S_DONE;
                  end
               end
            end
            S_BUSY: begin
`ifdef SEQ_ALU_MDU_EN
               if (mdu_done) begin
                  alu_out_q <= mdu_res;
                  state_q   <= S_DONE;
               end
`else
               state_q <= S_IDLE;
`endif
            end
            S_DONE: begin
               if (out_ready) begin
                  state_q <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign in_ready   = (state_q == S_IDLE);
   assign out_valid  = (state_q == S_DONE);
   assign alu_out    = alu_out_q;
   assign Zero       = zero_q;
   assign Less       = less_q;
   assign illegal_op = illegal_q;

endmodule

// File: tb/tb_seq_alu.sv
module tb_seq_alu;
   import seq_alu_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        flush = 1'b0;
   logic        out_ready = 1'b0;
   logic [4:0]  alu_op = '0;
   logic [31:0] A = '0;
   logic [31:0] B = '0;
   logic        in_ready, out_valid, Zero, Less, illegal_op;
   logic [31:0] alu_out;

   logic        in_valid64 = 1'b0;
   logic        out_ready64 = 1'b0;
   logic [4:0]  alu_op64 = '0;
   logic [63:0] A64 = '0;
   logic [63:0] B64 = '0;
   logic        in_ready64, out_valid64, Zero64, Less64, illegal64;
   logic [63:0] alu_out64;

   int          n_pass = 0;
   int          n_total = 0;
   int          lat;
   logic        rdy_in_busy;
   logic        stable_ok;

   always #5 clk = ~clk;

   seq_alu u_dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .alu_op     (alu_op),
      .A          (A),
      .B          (B),
      .flush      (flush),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .alu_out    (alu_out),
      .Zero       (Zero),
      .Less       (Less),
      .illegal_op (illegal_op)
   );

   seq_alu #(.DATA_WIDTH(64)) u_dut64 (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid64),
      .in_ready   (in_ready64),
      .alu_op     (alu_op64),
      .A          (A64),
      .B          (B64),
      .flush      (flush),
      .out_valid  (out_valid64),
      .out_ready  (out_ready64),
      .alu_out    (alu_out64),
      .Zero       (Zero64),
      .Less       (Less64),
      .illegal_op (illegal64)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total = n_total + 1;
      assert (obs === exp) n_pass = n_pass + 1;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Accept one op, then wait (bounded) for out_valid. lat counts the edges
   // after the accepting edge; 0 means out_valid right after accept.
   task automatic issue_wait(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
      alu_op   = op;
      A        = a;
      B        = b;
      in_valid = 1'b1;
      step();
      in_valid    = 1'b0;
      lat         = 0;
      rdy_in_busy = 1'b0;
      while (!out_valid && lat < 200) begin
         if (in_ready) rdy_in_busy = 1'b1;
         step();
         lat = lat + 1;
      end
   endtask

   task automatic consume();
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      step();
      step();
      rst = 1'b0;

      // Reset in the middle of an operation (BUSY when the MDU is built).
      alu_op   = ALU_CTRL_MULH;
      A        = 32'h8000_0000;
      B        = 32'h8000_0000;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      step();
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("rst_in_ready",  in_ready,   1);
      chk("rst_out_valid", out_valid,  0);
      chk("rst_alu_out",   alu_out,    0);
      chk("rst_zero",      Zero,       0);
      chk("rst_less",      Less,       0);
      chk("rst_illegal",   illegal_op, 0);

      issue_wait(ALU_CTRL_ADD, 32'd5, 32'd7);
      chk("add_lat",     lat,        0);
      chk("add_out",     alu_out,    32'd12);
      chk("add_zero",    Zero,       0);
      chk("add_less",    Less,       0);
      chk("add_illegal", illegal_op, 0);
      consume();
      chk("add_idle", in_ready, 1);

      issue_wait(ALU_CTRL_SLT, 32'hFFFF_FFFF, 32'd1);
      chk("slt_out",  alu_out, 32'd1);
      chk("slt_less", Less,    1);
      consume();

      issue_wait(ALU_CTRL_SLTU, 32'hFFFF_FFFF, 32'd1);
      chk("sltu_out",  alu_out, 32'd0);
      chk("sltu_less", Less,    0);
      consume();

      issue_wait(ALU_CTRL_SRA, 32'h8000_0000, 32'd31);
      chk("sra_out", alu_out, 32'hFFFF_FFFF);
      consume();

      issue_wait(ALU_CTRL_SRL, 32'h8000_0000, 32'd31);
      chk("srl_out", alu_out, 32'd1);
      consume();

      // Only B[4:0] is used as shift amount: 36 shifts by 4.
      issue_wait(ALU_CTRL_SLL, 32'd1, 32'd36);
      chk("sll_shamt", alu_out, 32'd16);
      consume();

      issue_wait(ALU_CTRL_SUB, 32'd9, 32'd9);
      chk("sub_out",  alu_out, 32'd0);
      chk("sub_zero", Zero,    1);
      consume();

      issue_wait(ALU_CTRL_COPY_B, 32'd3, 32'hDEAD_BEEF);
      chk("copyb_out", alu_out, 32'hDEAD_BEEF);
      consume();

      issue_wait(5'h0B, 32'd3, 32'd4);
      chk("unk_out",     alu_out,    0);
      chk("unk_illegal", illegal_op, 1);
      chk("unk_lat",     lat,        0);
      consume();

`ifdef SEQ_ALU_MDU_EN
      issue_wait(ALU_CTRL_MULH, 32'h8000_0000, 32'h8000_0000);
      chk("mulh_out",  alu_out,     32'h4000_0000);
      chk("mulh_lat",  lat,         32);
      chk("mulh_busy", rdy_in_busy, 0);
      consume();

      issue_wait(ALU_CTRL_MUL, 32'd7, 32'hFFFF_FFFD);
      chk("mul_out", alu_out, 32'hFFFF_FFEB);
      chk("mul_lat", lat,     32);
      consume();

      issue_wait(ALU_CTRL_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      chk("mulhu_out", alu_out, 32'hFFFF_FFFE);
      consume();

      issue_wait(ALU_CTRL_DIV, 32'hFFFF_FFF9, 32'd2);
      chk("div_out", alu_out, 32'hFFFF_FFFD);
      consume();

      issue_wait(ALU_CTRL_REM, 32'hFFFF_FFF9, 32'd2);
      chk("rem_out", alu_out, 32'hFFFF_FFFF);
      consume();

      issue_wait(ALU_CTRL_DIVU, 32'd7, 32'd0);
      chk("divu0_out", alu_out, 32'hFFFF_FFFF);
      chk("divu0_lat", lat,     0);
      consume();

      issue_wait(ALU_CTRL_REMU, 32'd7, 32'd0);
      chk("remu0_out", alu_out, 32'd7);
      consume();

      issue_wait(ALU_CTRL_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
      chk("divovf_out", alu_out, 32'h8000_0000);
      chk("divovf_lat", lat,     0);
      consume();

      issue_wait(ALU_CTRL_REM, 32'h8000_0000, 32'hFFFF_FFFF);
      chk("removf_out", alu_out, 32'd0);
      consume();

      // Flush mid-BUSY: back to IDLE and no result ever appears.
      alu_op   = ALU_CTRL_DIV;
      A        = 32'd100;
      B        = 32'd3;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      for (int i = 0; i < 5; i++) step();
      flush = 1'b1;
      step();
      flush = 1'b0;
      chk("flushb_in_ready",  in_ready,  1);
      chk("flushb_out_valid", out_valid, 0);
      stable_ok = 1'b1;
      for (int i = 0; i < 40; i++) begin
         if (out_valid) stable_ok = 1'b0;
         step();
      end
      chk("flushb_no_result", stable_ok, 1);

      issue_wait(ALU_CTRL_DIVU, 32'd100, 32'd7);
      chk("divu_out", alu_out, 32'd14);
      chk("divu_lat", lat,     32);
      consume();
`else
      issue_wait(ALU_CTRL_MUL, 32'd3, 32'd4);
      chk("nomdu_mul_out",     alu_out,    0);
      chk("nomdu_mul_illegal", illegal_op, 1);
      chk("nomdu_mul_lat",     lat,        0);
      consume();

      issue_wait(ALU_CTRL_DIVU, 32'd7, 32'd0);
      chk("nomdu_divu_out",     alu_out,    0);
      chk("nomdu_divu_illegal", illegal_op, 1);
      consume();
`endif

      // Backpressure: DONE holds for 5 cycles while a new op is offered.
      issue_wait(ALU_CTRL_XOR, 32'h0000_F0F0, 32'h0000_0FF0);
      alu_op   = ALU_CTRL_ADD;
      A        = 32'd1;
      B        = 32'd2;
      in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("bp_out_valid", out_valid, 1);
         chk("bp_alu_out",   alu_out,   32'h0000_FF00);
         chk("bp_in_ready",  in_ready,  0);
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk("bp_release_valid", out_valid, 0);
      chk("bp_release_ready", in_ready,  1);
      step();
      in_valid = 1'b0;
      chk("bp_next_valid", out_valid, 1);
      chk("bp_next_out",   alu_out,   32'd3);
      consume();

      // Flush in DONE drops the result.
      issue_wait(ALU_CTRL_OR, 32'd1, 32'd2);
      flush = 1'b1;
      step();
      flush = 1'b0;
      chk("flushd_out_valid", out_valid, 0);
      chk("flushd_in_ready",  in_ready,  1);

      // Flush wins over in_valid in IDLE.
      alu_op   = ALU_CTRL_AND;
      A        = 32'hFF;
      B        = 32'h0F;
      in_valid = 1'b1;
      flush    = 1'b1;
      step();
      in_valid = 1'b0;
      flush    = 1'b0;
      chk("flushi_out_valid", out_valid, 0);
      chk("flushi_in_ready",  in_ready,  1);

      // 64-bit instance.
      alu_op64   = ALU_CTRL_SLL;
      A64        = 64'd1;
      B64        = 64'd63;
      in_valid64 = 1'b1;
      step();
      in_valid64 = 1'b0;
      chk("w64_valid",   out_valid64, 1);
      chk("w64_sll",     alu_out64,   64'h8000_0000_0000_0000);
      chk("w64_less",    Less64,      0);
      chk("w64_illegal", illegal64,   0);
      chk("w64_zero",    Zero64,      0);
      chk("w64_ready",   in_ready64,  0);
      out_ready64 = 1'b1;
      step();
      out_ready64 = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
